ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_fifo.sv | 66 ++++++
 rtl/ifetch.sv | 111 +++++++++++
 tb/tb_ifetch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package ifetch_pkg;

    localparam int XLEN         = 32;
    localparam int IFETCH_DEPTH = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with async reset, synchronous clear and an occupancy count.
module ifetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rd_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clr) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: credit-limited request issue, in-order response capture into a
// small buffer, and flush handling that drops responses to requests made before the redirect.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int DEPTH = IFETCH_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_cur,
    output logic            pc_adv,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e   state_q, state_d;
    logic [CW-1:0]  disc_q, disc_d;
    logic [CW-1:0]  pend, cnt;
    logic [CW+1:0]  credit;
    logic           accept, rsp_drop, rsp_live, id_pop;
    logic           aq_full, aq_empty, ib_full, ib_empty;
    logic [XLEN-1:0] aq_head;
    fetch_entry_t   ib_wdata, ib_head;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Every slot is reserved at request time: live, stale and buffered entries all count.
    assign credit         = (CW+2)'(pend) + (CW+2)'(disc_q) + (CW+2)'(cnt);
    assign imem_req_valid = (state_q == RUN) && !flush && (credit < (CW+2)'(DEPTH));
    assign imem_req_addr  = {pc_cur[XLEN-1:2], 2'b00};
    assign accept         = imem_req_valid && imem_req_ready;
    assign pc_adv         = accept;

    assign rsp_drop = imem_rsp_valid && (disc_q != '0);
    assign rsp_live = imem_rsp_valid && (disc_q == '0);

    // On flush, every live request becomes stale; one arriving this cycle is already gone.
    always_comb begin
        disc_d = disc_q;
        if (flush)         disc_d = disc_q + pend - CW'(imem_rsp_valid);
        else if (rsp_drop) disc_d = disc_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            disc_q  <= disc_d;
        end
    end

    assign ib_wdata = '{pc: aq_head, instr: imem_rsp_data};

    ifetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (accept),
        .wdata (imem_req_addr),
        .pop   (rsp_live),
        .rdata (aq_head),
        .full  (aq_full),
        .empty (aq_empty),
        .count (pend)
    );

    ifetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (rsp_live),
        .wdata (ib_wdata),
        .pop   (id_pop),
        .rdata (ib_head),
        .full  (ib_full),
        .empty (ib_empty),
        .count (cnt)
    );

    assign id_valid = !ib_empty && !flush;
    assign id_pop   = id_valid && id_ready;
    assign id_instr = ib_empty ? '0 : ib_head.instr;
    assign id_pc    = ib_empty ? '0 : ib_head.pc;

    a_depth:  assert property (@(posedge clk) (DEPTH == 2) || (DEPTH == 4));
    a_credit: assert property (@(posedge clk) disable iff (rst) credit <= (CW+2)'(DEPTH));
    a_rsp:    assert property (@(posedge clk) disable iff (rst)
                               imem_rsp_valid |-> ((disc_q != '0) || !aq_empty));
    a_aq_ovf: assert property (@(posedge clk) disable iff (rst) !(aq_full && accept));
    a_ib_ovf: assert property (@(posedge clk) disable iff (rst) !(ib_full && rsp_live && !id_pop));

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a queue-based instruction memory and pc stage drive the DUT.
module tb_ifetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_cur;
    logic        pc_adv;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt, adv_cnt, rsp_budget;
    logic [31:0] memq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    event smp_ev;

    ifetch #(.DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_cur         (pc_cur),
        .pc_adv         (pc_adv),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        #4;
        ->smp_ev;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: sample just before the edge, then play memory and pc stage after it.
    task automatic tick();
        logic adv;
        @(smp_ev);
        adv = pc_adv;
        if (adv) adv_cnt++;
        if (imem_req_valid && imem_req_ready) begin
            acc_cnt++;
            memq.push_back(imem_req_addr);
        end
        if (id_valid && id_ready) begin
            got_pc.push_back(id_pc);
            got_instr.push_back(id_instr);
        end
        @(negedge clk);
        if (adv) pc_cur = pc_cur + 32'd4;
        if (memq.size() > 0 && rsp_budget > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq.pop_front());
            rsp_budget--;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic clear_model(input logic [31:0] pc);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        flush          = 1'b0;
        memq.delete();
        got_pc.delete();
        got_instr.delete();
        acc_cnt = 0;
        adv_cnt = 0;
        pc_cur  = pc;
    endtask

    task automatic reset_dut(input logic [31:0] pc);
        @(negedge clk);
        rst = 1'b1;
        clear_model(pc);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pc_cur = 32'h0;
        flush = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        id_ready = 1'b0;
        rsp_budget = 0;
        acc_cnt = 0;
        adv_cnt = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_pc_adv",    32'(pc_adv),         32'h0);
        check("rst_id_valid",  32'(id_valid),       32'h0);
        check("rst_id_instr",  id_instr,            32'h0);
        check("rst_id_pc",     id_pc,               32'h0);

        // Streaming from pc 0 with one-cycle memory latency
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        rsp_budget = 1000;
        reset_dut(32'h0);
        check("idle_no_req", 32'(imem_req_valid), 32'h0);
        tick();
        check("run_req_valid", 32'(imem_req_valid), 32'h1);
        check("run_req_addr",  imem_req_addr,       32'h0);
        tick();
        check("fill_not_yet", 32'(id_valid), 32'h0);
        tick();
        check("fill_id_valid", 32'(id_valid), 32'h1);
        check("fill_id_pc",    id_pc,         32'h0);
        check("fill_id_instr", id_instr,      mem_word(32'h0));
        repeat (16) tick();
        check("stream_count_ge6", 32'(got_pc.size() >= 6), 32'h1);
        for (int i = 0; i < 6; i++) begin
            check("stream_pc",    got_pc[i],    32'(4 * i));
            check("stream_instr", got_instr[i], mem_word(32'(4 * i)));
        end
        check("stream_adv_eq_acc", 32'(adv_cnt), 32'(acc_cnt));

        // Decode stalled: credit limits to DEPTH requests, head held
        id_ready = 1'b0;
        rsp_budget = 1000;
        reset_dut(32'h200);
        tick();
        repeat (8) tick();
        check("stall_acc_cnt",   32'(acc_cnt),        32'd2);
        check("stall_req_valid", 32'(imem_req_valid), 32'h0);
        check("stall_pc_adv",    32'(pc_adv),         32'h0);
        check("stall_id_valid",  32'(id_valid),       32'h1);
        check("stall_id_pc",     id_pc,               32'h200);
        repeat (3) tick();
        check("stall_hold_pc",    id_pc,    32'h200);
        check("stall_hold_instr", id_instr, mem_word(32'h200));
        id_ready = 1'b1;
        repeat (8) tick();
        check("stall_out0", got_pc[0], 32'h200);
        check("stall_out1", got_pc[1], 32'h204);
        check("stall_out2", got_pc[2], 32'h208);

        // Flush with two requests outstanding at 0x8 and 0xC
        id_ready = 1'b1;
        rsp_budget = 0;
        reset_dut(32'h8);
        tick();
        repeat (4) tick();
        check("fl_acc_cnt", 32'(acc_cnt),     32'd2);
        check("fl_mem_pend", 32'(memq.size()), 32'd2);
        flush = 1'b1;
        #1;
        check("fl_no_req", 32'(imem_req_valid), 32'h0);
        tick();
        flush = 1'b0;
        pc_cur = 32'h1000;
        #1;
        check("fl_disc_block", 32'(imem_req_valid), 32'h0);
        rsp_budget = 1000;
        repeat (10) tick();
        check("fl_first_pc",    got_pc[0],    32'h1000);
        check("fl_first_instr", got_instr[0], mem_word(32'h1000));
        check("fl_second_pc",   got_pc[1],    32'h1004);

        // Request ready toggling every cycle
        id_ready = 1'b1;
        rsp_budget = 1000;
        imem_req_ready = 1'b0;
        reset_dut(32'h3000);
        tick();
        for (int i = 0; i < 30; i++) begin
            imem_req_ready = ~imem_req_ready;
            tick();
        end
        imem_req_ready = 1'b0;
        repeat (6) tick();
        check("tog_adv_eq_acc", 32'(adv_cnt), 32'(acc_cnt));
        check("tog_out_eq_acc", 32'(got_pc.size()), 32'(acc_cnt));
        check("tog_some_acc", 32'(acc_cnt >= 5), 32'h1);
        for (int i = 0; i < got_pc.size(); i++) begin
            check("tog_pc", got_pc[i], 32'h3000 + 32'(4 * i));
        end

        // Asynchronous reset with one buffered and one pending
        id_ready = 1'b0;
        imem_req_ready = 1'b1;
        rsp_budget = 1;
        reset_dut(32'h40);
        tick();
        repeat (6) tick();
        check("ar_pre_id_valid",  32'(id_valid),       32'h1);
        check("ar_pre_req_valid", 32'(imem_req_valid), 32'h0);
        check("ar_pre_pending",   32'(memq.size()),    32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_req_valid", 32'(imem_req_valid), 32'h0);
        check("ar_pc_adv",    32'(pc_adv),         32'h0);
        check("ar_id_valid",  32'(id_valid),       32'h0);
        check("ar_id_instr",  id_instr,            32'h0);
        check("ar_id_pc",     id_pc,               32'h0);
        clear_model(32'h40);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ar_idle_no_req", 32'(imem_req_valid), 32'h0);
        tick();
        check("ar_restart_req",  32'(imem_req_valid), 32'h1);
        check("ar_restart_addr", imem_req_addr,       32'h40);
        id_ready = 1'b1;
        rsp_budget = 1000;
        repeat (8) tick();
        check("ar_first_pc",  got_pc[0], 32'h40);
        check("ar_second_pc", got_pc[1], 32'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
